// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the multiplexed clock display.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; anything outside 0..9 shows a dash.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [31:0] value,
    output logic [6:0]  pattern
);

    // Full 32-bit compare so stray high bits never alias onto a valid digit
    always_comb begin
        pattern = SEG_DASH;
        case (value)
            32'd0:   pattern = SEG_0;
            32'd1:   pattern = SEG_1;
            32'd2:   pattern = SEG_2;
            32'd3:   pattern = SEG_3;
            32'd4:   pattern = SEG_4;
            32'd5:   pattern = SEG_5;
            32'd6:   pattern = SEG_6;
            32'd7:   pattern = SEG_7;
            32'd8:   pattern = SEG_8;
            32'd9:   pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed 7-segment driver with frame snapshot, dead time,
// leading-zero blanking and a blinking colon on the decimal point.
module seg_display_driver
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZB         = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] sec0,
    input  logic [31:0] sec1,
    input  logic [31:0] min0,
    input  logic [31:0] min1,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam digit_idx_t      IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);
    localparam digit_idx_t      IDX_COLON = digit_idx_t'(2);

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic [31:0]   snap [NUM_DIGITS];
    logic          colon;

    logic          slot_end;
    logic          frame_end;
    logic [31:0]   cur_digit;
    logic [6:0]    cur_pat;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot timer: cnt==0 is the dead-time cycle of every slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (slot_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // Digit index advances once per slot and wraps naturally at NUM_DIGITS
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (slot_end)
            idx <= idx + digit_idx_t'(1);
    end

    // Capture all inputs together at the end of a frame so one frame never mixes two times
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                snap[i] <= '0;
        end else if (frame_end) begin
            snap[0] <= sec0;
            snap[1] <= sec1;
            snap[2] <= min0;
            snap[3] <= min1;
        end
    end

    // Colon blink state, flipped by each tick pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            colon <= 1'b1;
        else if (tick)
            colon <= ~colon;
    end

    assign cur_digit = snap[idx];

    seg7_decode u_decode (
        .value   (cur_digit),
        .pattern (cur_pat)
    );

    // Next-output logic: blank during dead time, otherwise light the current digit
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (cnt != '0) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = cur_pat;
            if (LZB && (idx == IDX_LAST) && (snap[NUM_DIGITS-1] == 32'd0))
                an_d = 4'b1111;
        end
        dp_d = ~((idx == IDX_COLON) && (cnt != '0) && colon);
    end

    // Registered outputs so the pins see no decode glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV=4, LZB=1.
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [31:0] sec0, sec1, min0, min1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int   checks = 0;
    int   errors = 0;
    logic colon_m;
    logic [3:0] an_tab [4];

    seg_display_driver #(.REFRESH_DIV(4), .LZB(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .sec0  (sec0),
        .sec1  (sec1),
        .min0  (min0),
        .min1  (min1),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int n, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_off(input string tag, input int n);
        chk({tag, "_an"},  n, {3'b000, an}, 7'b0001111);
        chk({tag, "_seg"}, n, seg, 7'b1111111);
        chk({tag, "_dp"},  n, {6'b0, dp}, 7'b0000001);
    endtask

    // One display frame (or its first nsteps cycles); each step shows the state entered at its start
    task automatic frame(input string tag,
                         input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3,
                         input bit blank3, input int nsteps,
                         input int tick_step, input int chg_step, input logic [31:0] chg_val);
        logic [6:0] es [4];
        logic [3:0] ea;
        logic [6:0] eseg;
        logic       edp;
        int         i, c;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int j = 0; j < nsteps; j++) begin
            i = j / 4;
            c = j % 4;
            if (j == chg_step) sec1 = chg_val;
            if (j == tick_step) tick = 1'b1;
            if (c == 0) begin
                ea = 4'b1111; eseg = 7'b1111111; edp = 1'b1;
            end else begin
                ea   = (i == 3 && blank3) ? 4'b1111 : an_tab[i];
                eseg = es[i];
                edp  = !(i == 2 && colon_m);
            end
            step();
            tick = 1'b0;
            chk({tag, "_an"},  j, {3'b000, an}, {3'b000, ea});
            chk({tag, "_seg"}, j, seg, eseg);
            chk({tag, "_dp"},  j, {6'b0, dp}, {6'b0, edp});
            if (j == tick_step) colon_m = !colon_m;
        end
    endtask

    initial begin
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        reset = 1'b1; tick = 1'b0;
        sec0 = 0; sec1 = 0; min0 = 0; min1 = 0;
        colon_m = 1'b1;

        // Reset held for 10 cycles: everything dark
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_off("rst_hold", k);
        end

        // Inputs present at release are not shown until the first snapshot
        sec0 = 5; sec1 = 4; min0 = 3; min1 = 2;
        reset = 1'b0;
        frame("preA", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b1, 16, -1, -1, 0);

        // 5,4,3,2 displayed, colon on in slot 2
        frame("digB", 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 1'b0, 16, -1, -1, 0);

        // sec1 -> 6 during slot 1 must not tear; tick coincides with snapshot
        frame("tearC", 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 1'b0, 16, 15, 5, 32'd6);

        // New sec1 visible, colon now off
        frame("newD", 7'b0010010, 7'b0000010, 7'b0110000, 7'b0100100, 1'b0, 16, -1, -1, 0);

        // Out-of-range values (including high-bit aliasing of 3) and digits 8/9
        sec0 = 12; sec1 = 9; min0 = 32'h1000_0003; min1 = 8;
        frame("holdE", 7'b0010010, 7'b0000010, 7'b0110000, 7'b0100100, 1'b0, 16, 0, -1, 0);

        // Leading-zero blank with 7s elsewhere
        sec0 = 7; sec1 = 7; min0 = 7; min1 = 0;
        frame("dashF", 7'b0111111, 7'b0010000, 7'b0111111, 7'b0000000, 1'b0, 16, 0, -1, 0);

        frame("lzbG", 7'b1111000, 7'b1111000, 7'b1111000, 7'b1000000, 1'b1, 16, -1, -1, 0);

        // Into slot 2 with colon on, then one more tick so the colon is off before reset
        frame("midH", 7'b1111000, 7'b1111000, 7'b1111000, 7'b1000000, 1'b1, 10, 0, -1, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("midH_an",  10, {3'b000, an}, 7'b0001011);
        chk("midH_seg", 10, seg, 7'b1111000);
        chk("midH_dp",  10, {6'b0, dp}, 7'b0000000);
        colon_m = !colon_m;

        // Asynchronous reset mid-slot 2: outputs dark without waiting for a clock
        reset = 1'b1;
        #1;
        chk_off("rst_async", 0);
        colon_m = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk_off("rst_async", k);
        end
        reset = 1'b0;

        // Restart at idx 0 with dead time, cleared snapshot, colon back on
        frame("postI", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b1, 16, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
